// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access-size codes, FSM states,
// byte-enable base patterns and a misalignment helper.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] SC_B  = 3'b000;
    localparam logic [2:0] SC_H  = 3'b001;
    localparam logic [2:0] SC_W  = 3'b010;
    localparam logic [2:0] SC_BU = 3'b100;
    localparam logic [2:0] SC_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_byte_acc(input logic [2:0] sc);
        return (sc == SC_B) || (sc == SC_BU);
    endfunction

    function automatic logic is_half_acc(input logic [2:0] sc);
        return (sc == SC_H) || (sc == SC_HU);
    endfunction

    // Anything that is neither byte nor half is handled as a word access.
    function automatic logic is_word_acc(input logic [2:0] sc);
        return !is_byte_acc(sc) && !is_half_acc(sc);
    endfunction

    // Low address bits forced to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input logic [2:0] sc, input logic [1:0] a);
        if (is_byte_acc(sc))      return a;
        else if (is_half_acc(sc)) return {a[1], 1'b0};
        else                      return 2'b00;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a load word and sign- or
// zero-extends it; words pass through unchanged.
module load_extend
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      sc,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        uns;

    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        uns       = sc[2];
        data      = rdata;

        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        if (is_byte_acc(sc))
            data = {{24{byte_lane[7] & ~uns}}, byte_lane};
        else if (is_half_acc(sc))
            data = {{16{half_lane[15] & ~uns}}, half_lane};
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: data-memory handshake, store lane steering, load alignment,
// front-end stall and the MEM/WB register. MEM_MISALIGN_TRAP_EN enables
// misalignment trapping; otherwise unaligned low address bits are ignored.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned DMEM_AW = 32
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteM,
    input  logic               MemWriteM,
    input  logic               MemtoRegM,
    input  logic               PCBranchM,
    input  logic               branchM,
    input  logic [2:0]         strCtrlM,
    input  logic [XLEN-1:0]    ALUoutM,
    input  logic [XLEN-1:0]    r2M,
    input  logic [XLEN-1:0]    PCplusImmM,
    input  logic [4:0]         rdM,
    output logic               PCSrcM,
    output logic [XLEN-1:0]    PCTargetM,
    output logic               stallM,
    output logic               misalignM,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               dmem_ready,
    output logic               RegWriteW,
    output logic               MemtoRegW,
    output logic [XLEN-1:0]    ALUoutW,
    output logic [XLEN-1:0]    ReadDataW,
    output logic [4:0]         rdW
);

    state_t          state;
    logic            mem_op;
    logic            mis;
    logic [1:0]      lo;
    logic [XLEN-1:0] ld_data;

    assign PCSrcM    = PCBranchM & branchM;
    assign PCTargetM = PCplusImmM;

    assign mem_op = MemtoRegM | MemWriteM;
    assign lo     = align_lo(strCtrlM, ALUoutM[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & ((is_half_acc(strCtrlM) & ALUoutM[0]) |
                           (is_word_acc(strCtrlM) & (|ALUoutM[1:0])));
`else
    assign mis = 1'b0;
`endif

    // EX/MEM is frozen while stalled, so the request fields stay stable in WAIT.
    always_comb begin
        dmem_req   = ~rst & ((state == ST_WAIT) | (mem_op & ~mis));
        dmem_we    = dmem_req & MemWriteM;
        dmem_addr  = DMEM_AW'({ALUoutM[XLEN-1:2], 2'b00});
        dmem_be    = BE_WORD;
        dmem_wdata = r2M;
        if (MemWriteM) begin
            if (is_byte_acc(strCtrlM)) begin
                dmem_be    = BE_BYTE << lo;
                dmem_wdata = {4{r2M[7:0]}};
            end else if (is_half_acc(strCtrlM)) begin
                dmem_be    = BE_HALF << lo;
                dmem_wdata = {2{r2M[15:0]}};
            end
        end
        stallM = dmem_req & ~dmem_ready;
    end

    load_extend u_load_extend (
        .rdata (dmem_rdata),
        .addr  (lo),
        .sc    (strCtrlM),
        .data  (ld_data)
    );

    // FSM and registered MEM/WB outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            misalignM <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUoutW   <= '0;
            ReadDataW <= '0;
            rdW       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (dmem_req && !dmem_ready) state <= ST_WAIT;
                ST_WAIT: if (dmem_ready)              state <= ST_IDLE;
                default:                              state <= ST_IDLE;
            endcase

            misalignM <= mis;

            if (stallM) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM & ~mis;
                MemtoRegW <= MemtoRegM;
                ALUoutW   <= ALUoutM;
                ReadDataW <= ld_data;
                rdW       <= rdM;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; follows MEM_MISALIGN_TRAP_EN
// for the misaligned-word case.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
    logic [2:0]  strCtrlM;
    logic [31:0] ALUoutM, r2M, PCplusImmM;
    logic [4:0]  rdM;
    logic        PCSrcM;
    logic [31:0] PCTargetM;
    logic        stallM, misalignM, dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUoutW, ReadDataW;
    logic [4:0]  rdW;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access #(.DMEM_AW(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .PCBranchM(PCBranchM), .branchM(branchM), .strCtrlM(strCtrlM),
        .ALUoutM(ALUoutM), .r2M(r2M), .PCplusImmM(PCplusImmM), .rdM(rdM),
        .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .stallM(stallM), .misalignM(misalignM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUoutW(ALUoutW),
        .ReadDataW(ReadDataW), .rdW(rdW)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic rw, input logic mw, input logic m2r, input logic [2:0] sc,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        RegWriteM = rw; MemWriteM = mw; MemtoRegM = m2r; strCtrlM = sc;
        ALUoutM = addr; r2M = wd; rdM = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        PCBranchM = 1'b0; branchM = 1'b0; PCplusImmM = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 5'd3);
        tick(); tick();
        check("rst_req",      32'(dmem_req), 32'd0);
        check("rst_stall",    32'(stallM), 32'd0);
        check("rst_regwrite", 32'(RegWriteW), 32'd0);
        check("rst_memtoreg", 32'(MemtoRegW), 32'd0);
        check("rst_aluout",   ALUoutW, 32'h0);
        check("rst_readdata", ReadDataW, 32'h0);
        check("rst_rd",       32'(rdW), 32'd0);
        check("rst_misalign", 32'(misalignM), 32'd0);

        // Bubble with ready asserted: ready must be ignored.
        rst = 1'b0;
        set_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd5);
        dmem_ready = 1'b1;
        #1;
        check("bub_req",   32'(dmem_req), 32'd0);
        check("bub_stall", 32'(stallM), 32'd0);
        tick();
        check("bub_aluout",   ALUoutW, 32'h1234);
        check("bub_regwrite", 32'(RegWriteW), 32'd1);
        check("bub_rd",       32'(rdW), 32'd5);

        // LB 0x103, zero wait.
        set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 5'd7);
        dmem_rdata = 32'h80FF_FF00;
        #1;
        check("lb_req",   32'(dmem_req), 32'd1);
        check("lb_we",    32'(dmem_we), 32'd0);
        check("lb_be",    32'(dmem_be), 32'hF);
        check("lb_addr",  dmem_addr, 32'h100);
        check("lb_stall", 32'(stallM), 32'd0);
        tick();
        check("lb_data",     ReadDataW, 32'hFFFF_FF80);
        check("lb_memtoreg", 32'(MemtoRegW), 32'd1);

        // LBU back to back: request in the very next cycle.
        set_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 5'd8);
        #1;
        check("lbu_req", 32'(dmem_req), 32'd1);
        tick();
        check("lbu_data", ReadDataW, 32'h0000_0080);
        check("lbu_rd",   32'(rdW), 32'd8);

        // LH / LHU from upper half.
        set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h302, 32'h0, 5'd9);
        dmem_rdata = 32'h8001_0000;
        tick();
        check("lh_data", ReadDataW, 32'hFFFF_8001);
        set_op(1'b1, 1'b0, 1'b1, 3'b101, 32'h302, 32'h0, 5'd9);
        tick();
        check("lhu_data", ReadDataW, 32'h0000_8001);

        // SH 0x202 with 3 wait cycles.
        set_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'hABCD_1234, 5'd2);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sh_req",   32'(dmem_req), 32'd1);
            check("sh_we",    32'(dmem_we), 32'd1);
            check("sh_addr",  dmem_addr, 32'h200);
            check("sh_be",    32'(dmem_be), 32'hC);
            check("sh_wdata", dmem_wdata, 32'h1234_1234);
            check("sh_stall", 32'(stallM), 32'd1);
            tick();
            check("sh_regwrite_stalled", 32'(RegWriteW), 32'd0);
        end
        dmem_ready = 1'b1;
        #1;
        check("sh_done_stall", 32'(stallM), 32'd0);
        check("sh_done_req",   32'(dmem_req), 32'd1);
        tick();
        check("sh_aluout", ALUoutW, 32'h202);

        // LW at 0x6.
        set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h6, 32'h0, 5'd11);
        dmem_rdata = 32'h1122_3344;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        check("lwm_req",   32'(dmem_req), 32'd0);
        check("lwm_stall", 32'(stallM), 32'd0);
        tick();
        check("lwm_misalign", 32'(misalignM), 32'd1);
        check("lwm_regwrite", 32'(RegWriteW), 32'd0);
        set_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
        tick();
        check("lwm_misalign_pulse", 32'(misalignM), 32'd0);
`else
        check("lwm_req",  32'(dmem_req), 32'd1);
        check("lwm_addr", dmem_addr, 32'h4);
        check("lwm_be",   32'(dmem_be), 32'hF);
        tick();
        check("lwm_data",     ReadDataW, 32'h1122_3344);
        check("lwm_misalign", 32'(misalignM), 32'd0);
        check("lwm_regwrite", 32'(RegWriteW), 32'd1);
`endif

        // Branch pass-through while stalled, then reset mid-WAIT.
        set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 5'd12);
        PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h80;
        dmem_ready = 1'b0;
        #1;
        check("br_pcsrc",  32'(PCSrcM), 32'd1);
        check("br_target", PCTargetM, 32'h80);
        check("wait_stall", 32'(stallM), 32'd1);
        tick();
        check("wait_stall2",  32'(stallM), 32'd1);
        check("br_pcsrc_stl", 32'(PCSrcM), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_req",   32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(stallM), 32'd0);
        tick();
        check("rstw_regwrite", 32'(RegWriteW), 32'd0);
        check("rstw_aluout",   ALUoutW, 32'h0);
        check("rstw_readdata", ReadDataW, 32'h0);
        check("rstw_rd",       32'(rdW), 32'd0);
        rst = 1'b0;
        PCBranchM = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
        #1;
        check("rstw_idle_req", 32'(dmem_req), 32'd0);
        check("br_pcsrc_off",  32'(PCSrcM), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the five-stage pipeline: the consumer of the EX/MEM pipeline register produced by the execute stage. Issues loads and stores to the data-memory port with a ready handshake, and aligns and extends load data. Stalls the front of the pipeline while an access is outstanding and registers the MEM/WB pipeline outputs. Also resolves the branch decision (PCBranchM & branchM) for the fetch stage.

## Interface
- DMEM_AW, 32, data-memory byte-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM  in  1 each  EX/MEM control bits
- strCtrlM  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- ALUoutM  in  32  effective address / ALU result
- r2M  in  32  store data
- PCplusImmM  in  32  branch target
- rdM  in  5  destination register
- PCSrcM  out  1  PCBranchM & branchM, combinational
- PCTargetM  out  32  PCplusImmM, combinational
- stallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalignM  out  1  one-cycle flag for a misaligned access
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DMEM_AW  word-aligned address (ALUoutM with [1:0] = 00)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  load data, valid when dmem_ready
- dmem_ready  in  1  access completes this cycle
- RegWriteW, MemtoRegW  out  1 each  MEM/WB control
- ALUoutW, ReadDataW  out  32 each  MEM/WB data
- rdW  out  5  MEM/WB destination

## Operation
- Memory op = MemtoRegM | MemWriteM. A bubble has all three write bits at 0.
- FSM states:
  - IDLE: on a memory op with no misalignment, drive dmem_req = 1 combinationally.
    - dmem_ready = 1 the same cycle: access completes, stay in IDLE.
    - Otherwise: go to WAIT.
  - WAIT: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata held at the same values. On dmem_ready, complete and go to IDLE.
- stallM = memory op & ~completion, in both states. The EX/MEM inputs are held stable by the upstream stages while stallM = 1.
- Store lanes:
  - byte: wdata = {4{r2M[7:0]}}, be = 0001 << addr[1:0].
  - half: wdata = {2{r2M[15:0]}}, be = 0011 << addr[1:0].
  - word: wdata = r2M, be = 1111.
  - Loads drive be = 1111 and dmem_we = 0.
- Load extract: select the byte or half lane by addr[1:0], then sign- or zero-extend according to strCtrlM[2].
- Misalignment:
  - Condition: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Response: no dmem_req, misalignM = 1 for one cycle, no stall, RegWriteW forced to 0, store dropped.
- MEM/WB register update, each cycle:
  - On completion or a non-memory op: capture RegWriteM, MemtoRegM, ALUoutM, the extracted load data, and rdM.
  - While stallM = 1: load a bubble (RegWriteW = 0, MemtoRegW = 0). Data fields hold their previous values.
- PCSrcM/PCTargetM are pass-through and are not gated by the stall.

## Timing
- Reset (synchronous, rst = 1 at a clk edge):
  - state = IDLE.
  - RegWriteW, MemtoRegW = 0; ALUoutW, ReadDataW = 0; rdW = 0.
  - misalignM = 0.
  - dmem_req, stallM = 0 for as long as rst = 1.
- Zero-wait memory: a load or store takes 1 cycle, with the result on the W outputs at the next edge.
- N wait cycles: stallM is high for N cycles and the W output updates one edge after dmem_ready.
- Reset mid-WAIT: the FSM returns to IDLE, dmem_req drops immediately, and the pending access is abandoned; the memory must tolerate a dropped request.
- dmem_ready while dmem_req = 0 is ignored.
- Back-to-back memory ops: the next request may be issued in the cycle after completion; there is no dead cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN:
  - Defined: misalignment detection and the misalignM behaviour are as above.
  - Undefined: misalignM is tied to 0, and addr low bits below the access size are ignored. For half accesses addr[0] is treated as 0; for word accesses addr[1:0] is treated as 00. The access proceeds normally.

## Structure
- Package mem_pkg:
  - strCtrl encodings (SC_B, SC_H, SC_W, SC_BU, SC_HU).
  - FSM state enum (ST_IDLE, ST_WAIT).
  - Byte-enable base constants.
- Sub-module load_extend: combinational; takes dmem_rdata, addr[1:0] and strCtrlM, and produces the 32-bit extended load value.

## Test plan
- Bubble: RegWriteM = 1, ALUoutM = 0x1234 with no memory op → no dmem_req, no stall; next edge ALUoutW = 0x1234, RegWriteW = 1.
- LB at 0x103, dmem_ready same cycle, rdata = 0x80FF_FF00 → be = 1111; next edge ReadDataW = 0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at 0x202, r2M = 0xABCD1234, dmem_ready after 3 wait cycles → dmem_addr = 0x200, be = 1100, wdata = 0x12341234; stallM high for 3 cycles, with RegWriteW = 0 during the stall.
- LW at 0x0006 with MEM_MISALIGN_TRAP_EN defined → no dmem_req, misalignM pulses for 1 cycle, RegWriteW = 0. With the macro undefined → request issued with dmem_addr = 0x0004.
- Load in WAIT, rst asserted → next edge state = IDLE, stallM = 0, dmem_req = 0, all W outputs = 0.
- PCBranchM = 1, branchM = 1, PCplusImmM = 0x80 → PCSrcM = 1 and PCTargetM = 0x80 in the same cycle, also while stalled.
